// File: rtl/sddac_pkg.sv
// Shared types, DSP opcodes and arithmetic helpers for the sigma-delta DAC sequencer.
// Opcodes and saturation/clamp helpers are used by sddac_mod2_seq.
package sddac_pkg;

    localparam logic [7:0] OP_MAC  = 8'h0D;
    localparam logic [7:0] OP_IDLE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE1,
        ST_WAIT1,
        ST_CAP1,
        ST_ISSUE2,
        ST_WAIT2,
        ST_CAP2,
        ST_UPDATE
    } state_t;

    function automatic logic signed [17:0] sat18(input logic signed [47:0] v);
        if (v > 48'sd131071) begin
            return 18'sd131071;
        end else if (v < -48'sd131072) begin
            return -18'sd131072;
        end else begin
            return v[17:0];
        end
    endfunction

    function automatic logic signed [47:0] sx18(input logic signed [17:0] v);
        return {{30{v[17]}}, v};
    endfunction

    function automatic logic signed [47:0] clamp_s48(input logic signed [47:0] v,
                                                     input int unsigned w);
        logic signed [47:0] hi;
        logic signed [47:0] lo;
        hi = (48'sd1 <<< (w - 1)) - 48'sd1;
        lo = -(48'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/sddac_tick_gen.sv
// Oversampling tick generator: counts 0..DIV-1 while enabled, held at 0 otherwise.
// tick_o is high in the last count cycle, so the consumer acts as the count wraps to 0.
module sddac_tick_gen #(
    parameter int unsigned DIV = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sddac_mod2_seq.sv
// 2nd-order sigma-delta modulator sequencer time-sharing one pipelined MAC slice.
// Optional integrator clamp enabled by defining SDDAC_INT_CLAMP_EN.
module sddac_mod2_seq
    import sddac_pkg::*;
#(
    parameter int unsigned        DIV     = 16,
    parameter int unsigned        DSP_LAT = 3,
    parameter logic signed [17:0] K1      = 18'sd1,
    parameter logic signed [17:0] K2      = 18'sd1,
    parameter int unsigned        SHIFT   = 0,
    parameter int unsigned        FB_MAG  = 65536,
    parameter int unsigned        CLAMP_W = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [17:0] sample_in,
    input  logic        sample_valid,
    output logic [7:0]  dsp_op,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [47:0] dsp_c,
    input  logic [47:0] dsp_p,
    output logic        sd_out,
    output logic        sd_strobe,
    output logic        busy
);

    if (DIV < 2 * DSP_LAT + 2 || DSP_LAT < 2 || CLAMP_W < 2 || CLAMP_W > 48) begin : g_cfg_err
        $error("sddac_mod2_seq: illegal DIV/DSP_LAT/CLAMP_W configuration");
    end

    localparam int unsigned       WW        = $clog2(DSP_LAT);
    localparam logic [WW-1:0]     WAIT_INIT = WW'(DSP_LAT - 2);
    localparam logic signed [47:0] FB_POS   = 48'(FB_MAG);

    state_t             state_q, state_d;
    logic [WW-1:0]      wait_q, wait_d;
    logic signed [47:0] int1_q, int1_d;
    logic signed [47:0] int2_q, int2_d;
    logic [17:0]        x_hold_q;
    logic [7:0]         op_q, op_d;
    logic signed [17:0] a_q, a_d;
    logic signed [17:0] b_q, b_d;
    logic signed [47:0] c_q, c_d;
    logic               sd_out_q, sd_out_d;
    logic               strobe_q, strobe_d;
    logic               tick;
    logic signed [47:0] fb;

    function automatic logic signed [47:0] capture(input logic signed [47:0] v);
`ifdef SDDAC_INT_CLAMP_EN
        return clamp_s48(v, CLAMP_W);
`else
        return v;
`endif
    endfunction

    sddac_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(reset),
        .en_i  (en),
        .tick_o(tick)
    );

    assign fb = sd_out_q ? FB_POS : -FB_POS;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_hold_q <= '0;
        end else if (sample_valid) begin
            x_hold_q <= sample_in;
        end
    end

    // Operands are registered on entry to ISSUEn and held until CAPn; step-2
    // operands are formed from the value being captured so ISSUE2 follows CAP1 directly.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        int1_d   = int1_q;
        int2_d   = int2_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        sd_out_d = sd_out_q;
        strobe_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_UPDATE: begin
                state_d = ST_IDLE;
                if (tick) begin
                    state_d = ST_ISSUE1;
                    op_d    = OP_MAC;
                    a_d     = K1;
                    b_d     = sat18(sx18($signed(x_hold_q)) - fb);
                    c_d     = int1_q;
                end
            end
            ST_ISSUE1: begin
                state_d = ST_WAIT1;
                wait_d  = WAIT_INIT;
            end
            ST_WAIT1: begin
                if (wait_q == '0) begin
                    state_d = ST_CAP1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_CAP1: begin
                int1_d  = capture($signed(dsp_p));
                a_d     = K2;
                b_d     = sat18(sx18(sat18(int1_d >>> SHIFT)) - fb);
                c_d     = int2_q;
                state_d = ST_ISSUE2;
            end
            ST_ISSUE2: begin
                state_d = ST_WAIT2;
                wait_d  = WAIT_INIT;
            end
            ST_WAIT2: begin
                if (wait_q == '0) begin
                    state_d = ST_CAP2;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_CAP2: begin
                int2_d   = capture($signed(dsp_p));
                sd_out_d = ~int2_d[47];
                strobe_d = 1'b1;
                op_d     = OP_IDLE;
                state_d  = ST_UPDATE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            int1_q   <= '0;
            int2_q   <= '0;
            op_q     <= OP_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            sd_out_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            int1_q   <= int1_d;
            int2_q   <= int2_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            sd_out_q <= sd_out_d;
            strobe_q <= strobe_d;
        end
    end

    assign dsp_op    = op_q;
    assign dsp_a     = a_q;
    assign dsp_b     = b_q;
    assign dsp_c     = c_q;
    assign sd_out    = sd_out_q;
    assign sd_strobe = strobe_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_UPDATE);

endmodule
